// File: rtl/regfile_pkg.sv
// Shared constants and FSM state type for the 32-entry register bank.
package regfile_pkg;

    localparam int NREGS  = 32;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int FLAT_W = NREGS * WIDTH;

    // Bank sequencing: normal operation or walking bulk clear.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage : regfile_pkg

// File: rtl/regfile_bank32_if.sv
// Write / reservation / clear bus of the register bank plus its published state.
interface regfile_bank32_if;
    import regfile_pkg::*;

    logic                wr_valid;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [WIDTH-1:0]    wr_data;
    logic                rsv_en;
    logic [ADDR_W-1:0]   rsv_addr;
    logic                clr_req;
    logic                clr_done;
    logic [NREGS-1:0]    busy;
    logic [FLAT_W-1:0]   data;

    // Issue/writeback side drives requests and observes the bank state.
    modport master (
        output wr_valid, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
        input  wr_ready, clr_done, busy, data
    );

    // The bank itself.
    modport slave (
        input  wr_valid, wr_addr, wr_data, rsv_en, rsv_addr, clr_req,
        output wr_ready, clr_done, busy, data
    );

endinterface : regfile_bank32_if

// File: rtl/regfile_bank32_dec5_32.sv
// 5-to-32 one-hot decoder with an enable; all outputs low when disabled.
module dec5_32
    import regfile_pkg::*;
(
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [NREGS-1:0]  o_onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_dec
            assign o_onehot[gi] = i_en && (i_addr == ADDR_W'(gi));
        end
    endgenerate

endmodule : dec5_32

// File: rtl/regfile_bank32.sv
// 32 x 32-bit register bank with one write port, busy scoreboard,
// sequenced bulk clear and a flattened output bus for the read mux.
module regfile_bank32
    import regfile_pkg::*;
#(
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    regfile_bank32_if.slave   bus
);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_clr_cnt_next;
    logic              r_wr_ready;
    logic              r_clr_done;
    logic              w_clr_done_next;
    logic [FLAT_W-1:0] r_data;
    logic [NREGS-1:0]  r_busy;

    logic              w_wr_fire;
    logic              w_rsv_fire;
    logic [NREGS-1:0]  w_wr_en;
    logic [NREGS-1:0]  w_rsv_set;
    logic [NREGS-1:0]  w_clr_sel;

    // While clearing, wr_ready is low so no write can fire; reservations
    // are gated explicitly because they have no handshake.
    assign w_wr_fire  = bus.wr_valid && r_wr_ready;
    assign w_rsv_fire = bus.rsv_en && (r_state == IDLE);

    dec5_32 u_dec_wr (
        .i_en     (w_wr_fire),
        .i_addr   (bus.wr_addr),
        .o_onehot (w_wr_en)
    );

    dec5_32 u_dec_rsv (
        .i_en     (w_rsv_fire),
        .i_addr   (bus.rsv_addr),
        .o_onehot (w_rsv_set)
    );

    // Register currently being zeroed by the clear walk.
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_clr_sel
            assign w_clr_sel[gi] = (r_state == CLEAR) && (r_clr_cnt == ADDR_W'(gi));
        end
    endgenerate

    // FSM next state: clear walks all 32 entries, then pulses done.
    always_comb begin
        w_state_next    = r_state;
        w_clr_cnt_next  = r_clr_cnt;
        w_clr_done_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.clr_req) begin
                    w_state_next   = CLEAR;
                    w_clr_cnt_next = '0;
                end
            end
            CLEAR: begin
                w_clr_cnt_next = r_clr_cnt + 1'b1;
                if (r_clr_cnt == ADDR_W'(NREGS - 1)) begin
                    w_state_next    = IDLE;
                    w_clr_done_next = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // FSM state, clear counter and registered handshake/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_clr_cnt  <= '0;
            r_wr_ready <= 1'b1;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_clr_cnt  <= w_clr_cnt_next;
            r_wr_ready <= (w_state_next == IDLE);
            r_clr_done <= w_clr_done_next;
        end
    end

    // Register contents: clear walk beats writes, register 0 optionally tied low.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst || ((ZERO_REG != 0) && (i == 0)) || w_clr_sel[i]) begin
                r_data[i*WIDTH +: WIDTH] <= '0;
            end else if (w_wr_en[i]) begin
                r_data[i*WIDTH +: WIDTH] <= bus.wr_data;
            end
        end
    end

    // Busy scoreboard: a reservation outranks a completing write to the same entry.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst || ((ZERO_REG != 0) && (i == 0)) || w_clr_sel[i]) begin
                r_busy[i] <= 1'b0;
            end else if (w_rsv_set[i]) begin
                r_busy[i] <= 1'b1;
            end else if (w_wr_en[i]) begin
                r_busy[i] <= 1'b0;
            end
        end
    end

    assign bus.wr_ready = r_wr_ready;
    assign bus.clr_done = r_clr_done;
    assign bus.busy     = r_busy;
    assign bus.data     = r_data;

endmodule : regfile_bank32

// File: tb/tb_regfile_bank32.sv
// Scoreboard bench for regfile_bank32: a driver applies stimulus each cycle
// and queues the state a reference model predicts after the next edge; a
// monitor pops and compares one entry per clock edge.
module tb_regfile_bank32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_bank32_if rf_if ();

    regfile_bank32 #(.ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if)
    );

    typedef struct {
        logic [1023:0] data;
        logic [31:0]   busy;
        logic          rdy;
        logic          done;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model: architectural register values and clear progress.
    logic [31:0] m_reg [32];
    logic [31:0] m_busy;
    bit          m_clearing;
    int          m_idx;
    bit          m_done;

    initial begin
        rf_if.wr_valid = 1'b0;
        rf_if.wr_addr  = '0;
        rf_if.wr_data  = '0;
        rf_if.rsv_en   = 1'b0;
        rf_if.rsv_addr = '0;
        rf_if.clr_req  = 1'b0;
        foreach (m_reg[i]) m_reg[i] = 'x;
        m_busy     = 'x;
        m_clearing = 1'b0;
        m_idx      = 0;
        m_done     = 1'b0;
    end

    // One cycle of stimulus; predicts the state visible after the next edge.
    task automatic step(input bit r, input bit wv, input logic [4:0] wa,
                        input logic [31:0] wd, input bit re, input logic [4:0] ra,
                        input bit cr);
        exp_t e;
        @(negedge clk);
        rst            = r;
        rf_if.wr_valid = wv;
        rf_if.wr_addr  = wa;
        rf_if.wr_data  = wd;
        rf_if.rsv_en   = re;
        rf_if.rsv_addr = ra;
        rf_if.clr_req  = cr;

        m_done = 1'b0;
        if (r) begin
            foreach (m_reg[i]) m_reg[i] = 32'h0;
            m_busy     = 32'h0;
            m_clearing = 1'b0;
            m_idx      = 0;
        end else if (!m_clearing) begin
            if (wv) begin
                if (wa != 5'd0) m_reg[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (re && ra != 5'd0) m_busy[ra] = 1'b1;
            if (cr) begin
                m_clearing = 1'b1;
                m_idx      = 0;
            end
        end else begin
            m_reg[m_idx]  = 32'h0;
            m_busy[m_idx] = 1'b0;
            if (m_idx == 31) begin
                m_clearing = 1'b0;
                m_done     = 1'b1;
            end else begin
                m_idx = m_idx + 1;
            end
        end

        for (int i = 0; i < 32; i++) e.data[i*32 +: 32] = m_reg[i];
        e.busy = m_busy;
        e.rdy  = !m_clearing;
        e.done = m_done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 5'd0, 32'h0, 0, 5'd0, 0);
    endtask

    // Monitor: one expected entry per edge, sampled after the edge settles.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (rf_if.data !== e.data) begin
                    bad++;
                    for (int i = 0; i < 32; i++) begin
                        if (rf_if.data[i*32 +: 32] !== e.data[i*32 +: 32]) begin
                            $display("FAIL data r%0d got=%h want=%h t=%0t", i,
                                     rf_if.data[i*32 +: 32], e.data[i*32 +: 32], $time);
                            break;
                        end
                    end
                end
                total++;
                if (rf_if.busy !== e.busy) begin
                    bad++;
                    $display("FAIL busy got=%h want=%h t=%0t", rf_if.busy, e.busy, $time);
                end
                total++;
                if (rf_if.wr_ready !== e.rdy) begin
                    bad++;
                    $display("FAIL wr_ready got=%b want=%b t=%0t", rf_if.wr_ready, e.rdy, $time);
                end
                total++;
                if (rf_if.clr_done !== e.done) begin
                    bad++;
                    $display("FAIL clr_done got=%b want=%b t=%0t", rf_if.clr_done, e.done, $time);
                end
            end
        end
    end

    initial begin
        // Reset
        step(1, 0, 5'd0, 32'h0, 0, 5'd0, 0);
        step(1, 0, 5'd0, 32'h0, 0, 5'd0, 0);
        idle(1);

        // Basic write, then zero-register write and reservation
        step(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 0);
        idle(1);
        step(0, 1, 5'd0, 32'h12345678, 1, 5'd0, 0);
        step(0, 0, 5'd0, 32'h0, 1, 5'd0, 0);
        idle(1);

        // Reservation, completing write, then both in one cycle
        step(0, 0, 5'd0, 32'h0, 1, 5'd7, 0);
        step(0, 1, 5'd7, 32'h000000A5, 0, 5'd0, 0);
        step(0, 1, 5'd7, 32'h00000077, 1, 5'd7, 0);
        step(0, 1, 5'd8, 32'h00000088, 1, 5'd9, 0);
        idle(1);

        // Full fill, then clear with wr_valid/clr_req/rsv_en held during it
        for (int i = 0; i < 32; i++) step(0, 1, 5'(i), 32'hFFFFFFFF, 1, 5'(i), 0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 1);
        for (int k = 0; k < 34; k++)
            step(0, 1, 5'($urandom_range(0, 31)), $urandom, 1, 5'($urandom_range(0, 31)), k[0]);
        idle(2);

        // Reset in the middle of a clear
        for (int i = 0; i < 32; i++) step(0, 1, 5'(i), 32'hFFFFFFFF, 0, 5'd0, 0);
        step(0, 0, 5'd0, 32'h0, 0, 5'd0, 1);
        idle(9);
        step(1, 0, 5'd0, 32'h0, 0, 5'd0, 0);
        idle(40);

        // Write landing in the same cycle as the clear request
        step(0, 1, 5'd3, 32'h00000055, 0, 5'd0, 1);
        idle(36);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            step(($urandom_range(0, 499) == 0),
                 $urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 79) == 0));
        end
        idle(2);

        // Drain the scoreboard within a bounded number of edges
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_bank32
